// File: rtl/log_writer_pkg.sv
// Shared types for the replicated-log writer and reader.
// Holds widths, the packed entry header and the writer state encoding.
package log_writer_pkg;

    localparam int DATA_W      = 512;
    localparam int DATA_BYTES  = DATA_W / 8;
    localparam int BYTE_SH     = $clog2(DATA_BYTES);
    localparam int HDR_ADDR_W  = 8;
    localparam int DATA_ADDR_W = 12;
    localparam int LEN_W       = 16;
    localparam int CNT_W       = LEN_W + 1;

    typedef struct packed {
        logic [31:0]            view;
        logic [63:0]            op_num;
        logic [DATA_ADDR_W-1:0] data_start_addr;
        logic [LEN_W-1:0]       len;
    } log_hdr_struct;

    localparam int LOG_HDR_W = $bits(log_hdr_struct);

    typedef enum logic [2:0] {
        ST_READY,
        ST_CHECK,
        ST_WR_DATA,
        ST_WR_HDR,
        ST_DRAIN,
        ST_RESP
    } writer_state_e;

    // Data lines occupied by a payload of len bytes (rounded up).
    function automatic logic [CNT_W-1:0] lines_for(
        input logic [LEN_W-1:0] len
    );
        logic [CNT_W-1:0] sum;
        sum = {1'b0, len} + CNT_W'(DATA_BYTES - 1);
        return sum >> BYTE_SH;
    endfunction

endpackage

// File: rtl/log_writer_datap.sv
// Writer datapath: latched request, working data address, line counter,
// committed head pointers and the free-space checks.
// Ports: strobes from the controller (req_take, cnt_load, line_take,
// line_wr, hdr_take), log tails in; heads, header word and flags out.
module log_writer_datap
    import log_writer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_take,
    input  logic [31:0]            req_view,
    input  logic [63:0]            req_op_num,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   cnt_load,
    input  logic                   line_take,
    input  logic                   line_wr,
    input  logic                   hdr_take,
    input  logic [HDR_ADDR_W-1:0]  hdr_tail,
    input  logic [DATA_ADDR_W-1:0] data_tail,
    output logic [HDR_ADDR_W-1:0]  hdr_head,
    output logic [DATA_ADDR_W-1:0] data_head,
    output logic [DATA_ADDR_W-1:0] cur_addr,
    output logic                   lines_zero,
    output logic                   no_room,
    output logic                   last_line,
    output logic [LOG_HDR_W-1:0]   hdr_word
);

    logic [31:0]            view_q;
    logic [63:0]            op_q;
    logic [LEN_W-1:0]       len_q;
    logic [DATA_ADDR_W-1:0] start_q;
    logic [CNT_W-1:0]       remain;
    logic [CNT_W-1:0]       lines;
    logic [HDR_ADDR_W-1:0]  free_hdr;
    logic [DATA_ADDR_W-1:0] free_data;
    log_hdr_struct          hdr;

    // One slot/line always stays empty so head==tail means empty.
    assign lines     = lines_for(len_q);
    assign free_hdr  = hdr_tail - hdr_head - HDR_ADDR_W'(1);
    assign free_data = data_tail - data_head - DATA_ADDR_W'(1);

    assign lines_zero = (lines == '0);
    assign no_room    = (free_hdr == '0) ||
                        (lines > CNT_W'(free_data));
    assign last_line  = (remain == CNT_W'(1));

    assign hdr.view            = view_q;
    assign hdr.op_num          = op_q;
    assign hdr.data_start_addr = start_q;
    assign hdr.len             = len_q;
    assign hdr_word            = hdr;

    always_ff @(posedge clk) begin
        if (rst) begin
            view_q    <= '0;
            op_q      <= '0;
            len_q     <= '0;
            start_q   <= '0;
            cur_addr  <= '0;
            remain    <= '0;
            hdr_head  <= '0;
            data_head <= '0;
        end else begin
            if (req_take) begin
                view_q   <= req_view;
                op_q     <= req_op_num;
                len_q    <= req_len;
                start_q  <= data_head;
                cur_addr <= data_head;
            end
            if (cnt_load)
                remain <= lines;
            if (line_take)
                remain <= remain - CNT_W'(1);
            if (line_wr)
                cur_addr <= cur_addr + DATA_ADDR_W'(1);
            // Heads commit only with the header, after all data.
            if (hdr_take) begin
                hdr_head  <= hdr_head + HDR_ADDR_W'(1);
                data_head <= cur_addr;
            end
        end
    end

endmodule

// File: rtl/log_writer_ctrl.sv
// Log writer: accepts an append request, streams payload lines into data
// memory, writes the header last, then returns a completion.
// Ports: request/payload streams in, data and header memory writes out,
// log tails in, committed heads out, completion out.
module log_writer_ctrl
    import log_writer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src_writer_req_val,
    input  logic [31:0]            src_writer_req_view,
    input  logic [63:0]            src_writer_req_op_num,
    input  logic [LEN_W-1:0]       src_writer_req_len,
    output logic                   writer_src_req_rdy,
    input  logic                   src_writer_data_val,
    input  logic [DATA_W-1:0]      src_writer_data,
    output logic                   writer_src_data_rdy,
    output logic                   writer_log_data_mem_wr_req_val,
    output logic [DATA_ADDR_W-1:0] writer_log_data_mem_wr_req_addr,
    output logic [DATA_W-1:0]      writer_log_data_mem_wr_req_data,
    input  logic                   log_data_mem_writer_wr_req_rdy,
    output logic                   writer_log_hdr_mem_wr_req_val,
    output logic [HDR_ADDR_W-1:0]  writer_log_hdr_mem_wr_req_addr,
    output logic [LOG_HDR_W-1:0]   writer_log_hdr_mem_wr_req_data,
    input  logic                   log_hdr_mem_writer_wr_req_rdy,
    input  logic [HDR_ADDR_W-1:0]  log_hdr_tail_addr,
    input  logic [DATA_ADDR_W-1:0] log_data_tail_addr,
    output logic [HDR_ADDR_W-1:0]  writer_hdr_head_addr,
    output logic [DATA_ADDR_W-1:0] writer_data_head_addr,
    output logic                   writer_dst_resp_val,
    output logic                   writer_dst_resp_ok,
    output logic [HDR_ADDR_W-1:0]  writer_dst_resp_hdr_addr,
    input  logic                   dst_writer_resp_rdy
);

    writer_state_e          state;
    logic                   req_rdy_q;
    logic                   hdr_val_q;
    logic                   resp_val_q;
    logic                   resp_ok_q;
    logic [HDR_ADDR_W-1:0]  resp_addr_q;
    logic [HDR_ADDR_W-1:0]  hdr_head;
    logic [DATA_ADDR_W-1:0] data_head;
    logic [DATA_ADDR_W-1:0] cur_addr;
    logic                   lines_zero;
    logic                   no_room;
    logic                   last_line;
    logic                   in_data;
    logic                   in_drain;
    logic                   req_take;
    logic                   data_xfer;
    logic                   drain_xfer;
    logic                   hdr_take;

    assign in_data  = (state == ST_WR_DATA);
    assign in_drain = (state == ST_DRAIN);

    assign req_take   = req_rdy_q & src_writer_req_val;
    assign data_xfer  = in_data & src_writer_data_val &
                        log_data_mem_writer_wr_req_rdy;
    assign drain_xfer = in_drain & src_writer_data_val;
    assign hdr_take   = hdr_val_q & log_hdr_mem_writer_wr_req_rdy;

    log_writer_datap u_datap (
        .clk        (clk),
        .rst        (rst),
        .req_take   (req_take),
        .req_view   (src_writer_req_view),
        .req_op_num (src_writer_req_op_num),
        .req_len    (src_writer_req_len),
        .cnt_load   (state == ST_CHECK),
        .line_take  (data_xfer | drain_xfer),
        .line_wr    (data_xfer),
        .hdr_take   (hdr_take),
        .hdr_tail   (log_hdr_tail_addr),
        .data_tail  (log_data_tail_addr),
        .hdr_head   (hdr_head),
        .data_head  (data_head),
        .cur_addr   (cur_addr),
        .lines_zero (lines_zero),
        .no_room    (no_room),
        .last_line  (last_line),
        .hdr_word   (writer_log_hdr_mem_wr_req_data)
    );

    // Payload passes straight through to memory; drained lines are
    // accepted unconditionally and dropped.
    assign writer_src_data_rdy =
        (in_data & log_data_mem_writer_wr_req_rdy) | in_drain;
    assign writer_log_data_mem_wr_req_val  = in_data & src_writer_data_val;
    assign writer_log_data_mem_wr_req_addr = cur_addr;
    assign writer_log_data_mem_wr_req_data = src_writer_data;

    assign writer_src_req_rdy             = req_rdy_q;
    assign writer_log_hdr_mem_wr_req_val  = hdr_val_q;
    assign writer_log_hdr_mem_wr_req_addr = hdr_head;
    assign writer_hdr_head_addr           = hdr_head;
    assign writer_data_head_addr          = data_head;
    assign writer_dst_resp_val            = resp_val_q;
    assign writer_dst_resp_ok             = resp_ok_q;
    assign writer_dst_resp_hdr_addr       = resp_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_READY;
            req_rdy_q   <= 1'b0;
            hdr_val_q   <= 1'b0;
            resp_val_q  <= 1'b0;
            resp_ok_q   <= 1'b0;
            resp_addr_q <= '0;
        end else begin
            unique case (state)
                ST_READY: begin
                    req_rdy_q <= 1'b1;
                    if (req_take) begin
                        req_rdy_q <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (no_room) begin
                        if (lines_zero) begin
                            resp_val_q <= 1'b1;
                            resp_ok_q  <= 1'b0;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (lines_zero) begin
                        hdr_val_q <= 1'b1;
                        state     <= ST_WR_HDR;
                    end else begin
                        state <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (data_xfer && last_line) begin
                        hdr_val_q <= 1'b1;
                        state     <= ST_WR_HDR;
                    end
                end
                ST_WR_HDR: begin
                    if (hdr_take) begin
                        hdr_val_q   <= 1'b0;
                        resp_val_q  <= 1'b1;
                        resp_ok_q   <= 1'b1;
                        resp_addr_q <= hdr_head;
                        state       <= ST_RESP;
                    end
                end
                ST_DRAIN: begin
                    if (drain_xfer && last_line) begin
                        resp_val_q <= 1'b1;
                        resp_ok_q  <= 1'b0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dst_writer_resp_rdy) begin
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                        state      <= ST_READY;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_log_writer_ctrl.sv
// Directed bench for log_writer_ctrl.
// Drives requests and payload, records memory writes and checks results.
module tb_log_writer_ctrl;
    import log_writer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   src_writer_req_val;
    logic [31:0]            src_writer_req_view;
    logic [63:0]            src_writer_req_op_num;
    logic [LEN_W-1:0]       src_writer_req_len;
    logic                   writer_src_req_rdy;
    logic                   src_writer_data_val;
    logic [DATA_W-1:0]      src_writer_data;
    logic                   writer_src_data_rdy;
    logic                   mem_val;
    logic [DATA_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]      mem_data;
    logic                   mem_rdy;
    logic                   hdr_val;
    logic [HDR_ADDR_W-1:0]  hdr_addr;
    logic [LOG_HDR_W-1:0]   hdr_data;
    logic                   hdr_rdy;
    logic [HDR_ADDR_W-1:0]  hdr_tail;
    logic [DATA_ADDR_W-1:0] data_tail;
    logic [HDR_ADDR_W-1:0]  hdr_head;
    logic [DATA_ADDR_W-1:0] data_head;
    logic                   resp_val;
    logic                   resp_ok;
    logic [HDR_ADDR_W-1:0]  resp_addr;
    logic                   resp_rdy;

    logic mem_fix, tog_en;
    logic tgl = 1'b0;
    always @(negedge clk) tgl <= ~tgl;
    assign mem_rdy = tog_en ? tgl : mem_fix;

    logic [15:0] pay_idx = '0;
    assign src_writer_data = {{(DATA_W-16){1'b0}}, pay_idx};

    log_writer_ctrl dut (
        .clk                             (clk),
        .rst                             (rst),
        .src_writer_req_val              (src_writer_req_val),
        .src_writer_req_view             (src_writer_req_view),
        .src_writer_req_op_num           (src_writer_req_op_num),
        .src_writer_req_len              (src_writer_req_len),
        .writer_src_req_rdy              (writer_src_req_rdy),
        .src_writer_data_val             (src_writer_data_val),
        .src_writer_data                 (src_writer_data),
        .writer_src_data_rdy             (writer_src_data_rdy),
        .writer_log_data_mem_wr_req_val  (mem_val),
        .writer_log_data_mem_wr_req_addr (mem_addr),
        .writer_log_data_mem_wr_req_data (mem_data),
        .log_data_mem_writer_wr_req_rdy  (mem_rdy),
        .writer_log_hdr_mem_wr_req_val   (hdr_val),
        .writer_log_hdr_mem_wr_req_addr  (hdr_addr),
        .writer_log_hdr_mem_wr_req_data  (hdr_data),
        .log_hdr_mem_writer_wr_req_rdy   (hdr_rdy),
        .log_hdr_tail_addr               (hdr_tail),
        .log_data_tail_addr              (data_tail),
        .writer_hdr_head_addr            (hdr_head),
        .writer_data_head_addr           (data_head),
        .writer_dst_resp_val             (resp_val),
        .writer_dst_resp_ok              (resp_ok),
        .writer_dst_resp_hdr_addr        (resp_addr),
        .dst_writer_resp_rdy             (resp_rdy)
    );

    // Monitor of every handshake.
    logic [DATA_ADDR_W-1:0] wr_addr_q[$];
    logic [15:0]            wr_tag_q[$];
    int                     hdr_cnt = 0;
    int                     cons = 0;
    logic [HDR_ADDR_W-1:0]  last_hdr_addr = '0;
    logic [LOG_HDR_W-1:0]   last_hdr_data = '0;

    always @(posedge clk) begin
        if (mem_val && mem_rdy) begin
            wr_addr_q.push_back(mem_addr);
            wr_tag_q.push_back(mem_data[15:0]);
        end
        if (hdr_val && hdr_rdy) begin
            hdr_cnt       <= hdr_cnt + 1;
            last_hdr_addr <= hdr_addr;
            last_hdr_data <= hdr_data;
        end
        if (src_writer_data_val && writer_src_data_rdy) begin
            cons    <= cons + 1;
            pay_idx <= pay_idx + 16'd1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [31:0] v,
        input logic [63:0] op, input logic [11:0] st,
        input logic [15:0] ln);
        return {4'd0, v, op, st, ln};
    endfunction

    task automatic send(input logic [31:0] v, input logic [63:0] op,
                        input logic [15:0] ln);
        int n = 0;
        while (writer_src_req_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy", writer_src_req_rdy, 1);
        src_writer_req_val    = 1'b1;
        src_writer_req_view   = v;
        src_writer_req_op_num = op;
        src_writer_req_len    = ln;
        @(negedge clk);
        src_writer_req_val = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int budget);
        int n = 0;
        while (resp_val !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, resp_val, 1);
    endtask

    task automatic expect_resp(input string tag, input int budget,
                               input logic ok, input logic [7:0] a);
        wait_resp(tag, budget);
        check({tag, "_ok"}, resp_ok, ok);
        if (ok)
            check({tag, "_addr"}, resp_addr, a);
        @(negedge clk);
    endtask

    int w0, c0, h0, base, w1;

    initial begin
        rst = 1'b1;
        src_writer_req_val = 1'b0;
        src_writer_req_view = '0;
        src_writer_req_op_num = '0;
        src_writer_req_len = '0;
        src_writer_data_val = 1'b1;
        mem_fix = 1'b1;
        tog_en = 1'b0;
        hdr_rdy = 1'b1;
        resp_rdy = 1'b1;
        hdr_tail = '0;
        data_tail = '0;
        repeat (2) @(negedge clk);
        check("rst_req_rdy", writer_src_req_rdy, 0);
        check("rst_data_rdy", writer_src_data_rdy, 0);
        check("rst_mem_val", mem_val, 0);
        check("rst_hdr_val", hdr_val, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_resp_ok", resp_ok, 0);
        check("rst_heads", {hdr_head, data_head}, 20'h0);
        rst = 1'b0;

        // 1: single line into an empty log, exact latency.
        w0 = wr_addr_q.size();
        send(3, 7, 64);
        @(negedge clk);
        check("t1_mem_val", mem_val, 1);
        check("t1_mem_addr", mem_addr, 0);
        check("t1_resp_early", resp_val, 0);
        @(negedge clk);
        check("t1_hdr_val", hdr_val, 1);
        check("t1_hdr_addr", hdr_addr, 0);
        check("t1_hdr_data", hdr_data, mk_hdr(3, 7, 0, 64));
        check("t1_resp_early2", resp_val, 0);
        @(negedge clk);
        check("t1_resp_val", resp_val, 1);
        check("t1_resp_ok", resp_ok, 1);
        check("t1_resp_addr", resp_addr, 0);
        check("t1_heads", {hdr_head, data_head}, {8'd1, 12'd1});
        check("t1_nwr", wr_addr_q.size() - w0, 1);
        @(negedge clk);
        check("t1_resp_done", resp_val, 0);

        // 2: zero-length entry.
        w0 = wr_addr_q.size(); c0 = cons; h0 = hdr_cnt;
        send(1, 2, 0);
        expect_resp("t2_resp", 20, 1, 1);
        check("t2_nwr", wr_addr_q.size() - w0, 0);
        check("t2_cons", cons - c0, 0);
        check("t2_nhdr", hdr_cnt - h0, 1);
        check("t2_hdr", last_hdr_data, mk_hdr(1, 2, 1, 0));
        check("t2_heads", {hdr_head, data_head}, {8'd2, 12'd1});

        // Fill data memory up to line 4094 with large entries.
        for (int i = 0; i < 3; i++) begin
            send(9, 64'(i), 16'hFFFF);
            expect_resp("bulk_resp", 2000, 1, 8'(2 + i));
        end
        send(9, 3, 16'(1021 * 64));
        expect_resp("bulk_resp", 2000, 1, 5);
        check("bulk_heads", {hdr_head, data_head}, {8'd6, 12'd4094});

        // 3: data address wrap.
        data_tail = 12'd10;
        w0 = wr_addr_q.size(); base = int'(pay_idx);
        send(4, 5, 192);
        expect_resp("t3_resp", 20, 1, 6);
        check("t3_nwr", wr_addr_q.size() - w0, 3);
        check("t3_a0", wr_addr_q[w0], 4094);
        check("t3_a1", wr_addr_q[w0 + 1], 4095);
        check("t3_a2", wr_addr_q[w0 + 2], 0);
        check("t3_d0", wr_tag_q[w0], 16'(base));
        check("t3_d2", wr_tag_q[w0 + 2], 16'(base + 2));
        check("t3_hdr", last_hdr_data, mk_hdr(4, 5, 4094, 192));
        check("t3_heads", {hdr_head, data_head}, {8'd7, 12'd1});

        // 4: header memory full, payload drained.
        hdr_tail = 8'd8;
        w0 = wr_addr_q.size(); c0 = cons; h0 = hdr_cnt;
        send(6, 6, 130);
        expect_resp("t4_resp", 20, 0, 0);
        repeat (3) @(negedge clk);
        check("t4_cons", cons - c0, 3);
        check("t4_nwr", wr_addr_q.size() - w0, 0);
        check("t4_nhdr", hdr_cnt - h0, 0);
        check("t4_heads", {hdr_head, data_head}, {8'd7, 12'd1});

        // 4b: header full, zero length.
        c0 = cons; h0 = hdr_cnt;
        send(6, 7, 0);
        expect_resp("t4b_resp", 20, 0, 0);
        check("t4b_cons", cons - c0, 0);
        check("t4b_nhdr", hdr_cnt - h0, 0);

        // 4c: data memory full.
        hdr_tail = 8'd0; data_tail = 12'd2;
        w0 = wr_addr_q.size(); c0 = cons;
        send(6, 8, 64);
        expect_resp("t4c_resp", 20, 0, 0);
        check("t4c_cons", cons - c0, 1);
        check("t4c_nwr", wr_addr_q.size() - w0, 0);
        check("t4c_heads", {hdr_head, data_head}, {8'd7, 12'd1});

        // 5: memory back-pressure and response stall.
        data_tail = 12'd0; tog_en = 1'b1; resp_rdy = 1'b0;
        w0 = wr_addr_q.size(); c0 = cons; base = int'(pay_idx);
        send(8, 8, 256);
        wait_resp("t5_resp", 200);
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_val", resp_val, 1);
            check("t5_hold_ok", resp_ok, 1);
            check("t5_hold_addr", resp_addr, 7);
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        check("t5_resp_done", resp_val, 0);
        tog_en = 1'b0;
        check("t5_nwr", wr_addr_q.size() - w0, 4);
        check("t5_cons", cons - c0, 4);
        for (int k = 0; k < 4; k++) begin
            check("t5_addr", wr_addr_q[w0 + k], 12'(1 + k));
            check("t5_data", wr_tag_q[w0 + k], 16'(base + k));
        end
        check("t5_hdr", last_hdr_data, mk_hdr(8, 8, 1, 256));
        check("t5_heads", {hdr_head, data_head}, {8'd8, 12'd5});

        // 6: reset in the middle of a data burst.
        w0 = wr_addr_q.size();
        send(11, 11, 256);
        for (int n = 0; n < 20 && wr_addr_q.size() < w0 + 2; n++)
            @(negedge clk);
        check("t6_two_lines", wr_addr_q.size() - w0, 2);
        rst = 1'b1;
        @(negedge clk);
        check("t6_mem_val", mem_val, 0);
        check("t6_data_rdy", writer_src_data_rdy, 0);
        check("t6_hdr_val", hdr_val, 0);
        check("t6_resp_val", resp_val, 0);
        check("t6_heads", {hdr_head, data_head}, 20'h0);
        rst = 1'b0;
        w1 = wr_addr_q.size();
        send(12, 12, 64);
        expect_resp("t6_resp", 20, 1, 0);
        check("t6_nwr", wr_addr_q.size() - w1, 1);
        check("t6_addr", wr_addr_q[w1], 0);
        check("t6_hdr", last_hdr_data, mk_hdr(12, 12, 0, 64));
        check("t6_heads", {hdr_head, data_head}, {8'd1, 12'd1});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
